// File: rtl/iq_phase_pkg.sv
// Shared types and constants for the I/Q phase detector: FSM states, quadrant
// bases, guard-bit width and the CORDIC arctangent table.
package iq_phase_pkg;

  localparam int unsigned DEF_SAMPLE_WIDTH = 7;
  localparam int unsigned DEF_PHASE_WIDTH  = 16;
  localparam int unsigned DEF_ITERATIONS   = 12;

  localparam int unsigned XY_GUARD = 2;
  localparam int unsigned XY_WIDTH = DEF_SAMPLE_WIDTH + XY_GUARD;

  typedef enum logic [1:0] {
    IDLE,
    FOLD,
    ITER,
    DONE
  } state_e;

  localparam logic [1:0] QUAD0_BASE = 2'd0;
  localparam logic [1:0] QUAD1_BASE = 2'd1;
  localparam logic [1:0] QUAD2_BASE = 2'd2;
  localparam logic [1:0] QUAD3_BASE = 2'd3;

  // round(atan(2^-i)/(2*pi) * 2^pw); held at 2^16 scale and rescaled to pw
  function automatic logic [31:0] atan_lsb(input int unsigned i, input int unsigned pw);
    logic [31:0] a16;
    case (i)
      32'd0:   a16 = 32'd8192;
      32'd1:   a16 = 32'd4836;
      32'd2:   a16 = 32'd2555;
      32'd3:   a16 = 32'd1297;
      32'd4:   a16 = 32'd651;
      32'd5:   a16 = 32'd326;
      32'd6:   a16 = 32'd163;
      32'd7:   a16 = 32'd81;
      32'd8:   a16 = 32'd41;
      32'd9:   a16 = 32'd20;
      32'd10:  a16 = 32'd10;
      32'd11:  a16 = 32'd5;
      32'd12:  a16 = 32'd3;
      32'd13:  a16 = 32'd1;
      default: a16 = 32'd0;
    endcase
    if (pw >= 32'd16) begin
      atan_lsb = a16 << (pw - 32'd16);
    end else begin
      atan_lsb = (a16 + (32'd1 << (32'd15 - pw))) >> (32'd16 - pw);
    end
  endfunction

endpackage

// File: rtl/iq_quadrant_fold.sv
// Combinational quadrant fold: maps any I/Q vector into quadrant 0 and returns
// the quadrant's base phase plus a zero-vector flag.
module iq_quadrant_fold
  import iq_phase_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int unsigned PHASE_WIDTH  = DEF_PHASE_WIDTH,
  parameter int unsigned XYW          = XY_WIDTH
) (
  input  logic signed [SAMPLE_WIDTH-1:0] i_i,
  input  logic signed [SAMPLE_WIDTH-1:0] q_i,
  output logic signed [XYW-1:0]          x_o,
  output logic signed [XYW-1:0]          y_o,
  output logic        [PHASE_WIDTH-1:0]  z_o,
  output logic                           zero_o
);

  logic signed [XYW-1:0] i_ext;
  logic signed [XYW-1:0] q_ext;
  logic        [1:0]     quad;

  // guard bits are added before negation so the most negative sample survives
  assign i_ext = XYW'(i_i);
  assign q_ext = XYW'(q_i);

  always_comb begin
    x_o  = i_ext;
    y_o  = q_ext;
    quad = QUAD0_BASE;
    case ({i_i[SAMPLE_WIDTH-1], q_i[SAMPLE_WIDTH-1]})
      2'b00: begin
        x_o  = i_ext;
        y_o  = q_ext;
        quad = QUAD0_BASE;
      end
      2'b10: begin
        x_o  = q_ext;
        y_o  = -i_ext;
        quad = QUAD1_BASE;
      end
      2'b11: begin
        x_o  = -i_ext;
        y_o  = -q_ext;
        quad = QUAD2_BASE;
      end
      default: begin
        x_o  = -q_ext;
        y_o  = i_ext;
        quad = QUAD3_BASE;
      end
    endcase
  end

  assign z_o    = {quad, {(PHASE_WIDTH-2){1'b0}}};
  assign zero_o = (i_i == '0) && (q_i == '0);

endmodule

// File: rtl/iq_phase_detector.sv
// I/Q to phase converter: quadrant fold followed by iterative CORDIC vectoring.
// Define IQ_PHASE_INC_EN to add the phase_increment output (result delta).
module iq_phase_detector
  import iq_phase_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int unsigned PHASE_WIDTH  = DEF_PHASE_WIDTH,
  parameter int unsigned ITERATIONS   = DEF_ITERATIONS
) (
  input  logic                           clk,
  input  logic                           arst,
  input  logic                           sample_clk_ce,
  input  logic signed [SAMPLE_WIDTH-1:0] cosinewave,
  input  logic signed [SAMPLE_WIDTH-1:0] sinewave,
  output logic        [PHASE_WIDTH-1:0]  phase,
  output logic                           phase_valid,
  output logic                           busy,
  output logic                           overrun
`ifdef IQ_PHASE_INC_EN
  ,
  output logic        [PHASE_WIDTH-1:0]  phase_increment
`endif
);

  localparam int unsigned XYW  = SAMPLE_WIDTH + XY_GUARD;
  // fractional bits keep Y resolvable in late micro-rotations; without them a
  // stuck residual of -1 biases Z by the sum of the remaining ATAN terms
  localparam int unsigned FRAC = ITERATIONS;
  localparam int unsigned DW   = XYW + FRAC;
  localparam int unsigned CW   = $clog2(ITERATIONS + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(ITERATIONS - 1);

  state_e                         state_q, state_d;
  logic signed [SAMPLE_WIDTH-1:0] cos_q, sin_q;
  logic signed [DW-1:0]           x_q, y_q, x_d, y_d;
  logic signed [DW-1:0]           x_sh, y_sh;
  logic        [PHASE_WIDTH-1:0]  z_q, z_d, atan_i;
  logic                           zero_q;
  logic        [CW-1:0]           iter_q;
  logic        [PHASE_WIDTH-1:0]  phase_q, result;
  logic                           overrun_q;
  logic                           last_iter;

  logic signed [XYW-1:0]          fold_x, fold_y;
  logic        [PHASE_WIDTH-1:0]  fold_z;
  logic                           fold_zero;

  iq_quadrant_fold #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .PHASE_WIDTH (PHASE_WIDTH),
    .XYW         (XYW)
  ) u_fold (
    .i_i   (cos_q),
    .q_i   (sin_q),
    .x_o   (fold_x),
    .y_o   (fold_y),
    .z_o   (fold_z),
    .zero_o(fold_zero)
  );

  always_comb begin
    atan_i = PHASE_WIDTH'(atan_lsb(32'(iter_q), PHASE_WIDTH));
    x_sh   = x_q >>> iter_q;
    y_sh   = y_q >>> iter_q;
    if (!y_q[DW-1]) begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + atan_i;
    end else begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - atan_i;
    end
  end

  assign last_iter = (state_q == ITER) && (iter_q == LAST_ITER);
  assign result    = zero_q ? '0 : z_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_clk_ce) state_d = FOLD;
      FOLD:    state_d = ITER;
      ITER:    if (iter_q == LAST_ITER) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q   <= IDLE;
      cos_q     <= '0;
      sin_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      zero_q    <= 1'b0;
      iter_q    <= '0;
      phase_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= sample_clk_ce && (state_q != IDLE);
      if ((state_q == IDLE) && sample_clk_ce) begin
        cos_q <= cosinewave;
        sin_q <= sinewave;
      end
      if (state_q == FOLD) begin
        x_q    <= {fold_x, {FRAC{1'b0}}};
        y_q    <= {fold_y, {FRAC{1'b0}}};
        z_q    <= fold_z;
        zero_q <= fold_zero;
        iter_q <= '0;
      end
      if (state_q == ITER) begin
        x_q    <= x_d;
        y_q    <= y_d;
        z_q    <= z_d;
        iter_q <= iter_q + 1'b1;
      end
      // result is captured on entry to DONE so phase and phase_valid align
      if (last_iter) begin
        phase_q <= result;
      end
    end
  end

`ifdef IQ_PHASE_INC_EN
  logic [PHASE_WIDTH-1:0] prev_phase_q;
  logic [PHASE_WIDTH-1:0] phase_inc_q;

  always_ff @(posedge clk) begin
    if (arst) begin
      prev_phase_q <= '0;
      phase_inc_q  <= '0;
    end else if (last_iter) begin
      prev_phase_q <= result;
      phase_inc_q  <= result - prev_phase_q;
    end
  end

  assign phase_increment = phase_inc_q;
`endif

  assign phase       = phase_q;
  assign phase_valid = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_iq_phase_detector.sv
// Self-checking bench for iq_phase_detector against an ideal atan2 model.
module tb_iq_phase_detector;

  localparam int SW  = 7;
  localparam int PW  = 16;
  localparam int IT  = 12;
  localparam int LAT = IT + 2;
  localparam int T   = 256;
  localparam int FULL = 1 << PW;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic arst;
  logic ce;
  logic signed [SW-1:0] cosw;
  logic signed [SW-1:0] sinw;
  logic [PW-1:0] phase;
  logic pv;
  logic busy;
  logic ov;
`ifdef IQ_PHASE_INC_EN
  logic [PW-1:0] pinc;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iq_phase_detector #(
    .SAMPLE_WIDTH(SW),
    .PHASE_WIDTH (PW),
    .ITERATIONS  (IT)
  ) dut (
    .clk            (clk),
    .arst           (arst),
    .sample_clk_ce  (ce),
    .cosinewave     (cosw),
    .sinewave       (sinw),
    .phase          (phase),
    .phase_valid    (pv),
    .busy           (busy),
    .overrun        (ov)
`ifdef IQ_PHASE_INC_EN
    ,
    .phase_increment(pinc)
`endif
  );

  // tol=0: exact; tol>0: circular distance modulo 2^PW
  task automatic check(input string tag, input int got, input int exp, input int tol);
    int d;
    bit ok;
    total++;
    if (tol == 0) begin
      ok = (got == exp);
    end else begin
      d = (got - exp) & (FULL - 1);
      if (d > FULL / 2) d = FULL - d;
      ok = (d <= tol);
    end
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h tol=%0d", tag, got, exp, tol);
    end
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  function automatic int ideal_phase(input int c, input int s);
    real a;
    if (c == 0 && s == 0) return 0;
    a = $atan2(real'(s), real'(c)) / (2.0 * PI);
    if (a < 0.0) a = a + 1.0;
    return rnd(a * real'(FULL)) % FULL;
  endfunction

  function automatic int nco_cos(input int p);
    return rnd(63.0 * $cos(2.0 * PI * real'(p) / real'(FULL)));
  endfunction

  function automatic int nco_sin(input int p);
    return rnd(63.0 * $sin(2.0 * PI * real'(p) / real'(FULL)));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input int c, input int s, input int exp, input int tol);
    int n;
    cosw = SW'(c);
    sinw = SW'(s);
    ce   = 1'b1;
    tick();
    ce = 1'b0;
    n  = 1;
    while (!pv && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, LAT, 0);
    check(tag, int'(phase), exp, tol);
    tick();
  endtask

  // second strobe injected at cycle 'at' of the first calculation
  task automatic run_extra(input string tag, input int c, input int s, input int exp,
                           input int ec, input int es, input int at);
    int ovc;
    int vc;
    int lat;
    int ph;
    ovc = 0;
    vc  = 0;
    lat = 0;
    ph  = 0;
    cosw = SW'(c);
    sinw = SW'(s);
    ce   = 1'b1;
    tick();
    ce = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (n == at) begin
        cosw = SW'(ec);
        sinw = SW'(es);
        ce   = 1'b1;
      end
      tick();
      ce = 1'b0;
      if (ov) ovc++;
      if (pv) begin
        vc++;
        ph = int'(phase);
        if (lat == 0) lat = n + 1;
      end
    end
    check({tag, "_overruns"}, ovc, 1, 0);
    check({tag, "_valids"}, vc, 1, 0);
    check({tag, "_lat"}, lat, LAT, 0);
    check({tag, "_phase"}, ph, exp, T);
    check({tag, "_idle"}, int'(busy), 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vc;
    int c;
    int s;
    arst = 1'b1;
    ce   = 1'b0;
    cosw = '0;
    sinw = '0;
    repeat (3) tick();
    check("rst_phase", int'(phase), 0, 0);
    check("rst_valid", int'(pv), 0, 0);
    check("rst_busy", int'(busy), 0, 0);
    check("rst_overrun", int'(ov), 0, 0);
    arst = 1'b0;
    tick();

    run_vec("pos_x", 63, 0, 16'h0000, T);
    run_vec("pos_y", 0, 63, 16'h4000, T);
    run_vec("neg_x", -63, 0, 16'h8000, T);
    run_vec("neg_y", 0, -63, 16'hC000, T);
    run_vec("diag45", 45, 45, 16'h2000, T);
    run_vec("diag225", -64, -64, 16'hA000, T);
    run_vec("zero", 0, 0, 0, 0);

    run_extra("ovr_iter", 45, 45, 16'h2000, -63, 0, 5);
    run_extra("ovr_done", 0, -63, 16'hC000, 63, 0, LAT);

    cosw = SW'(-63);
    sinw = SW'(0);
    ce   = 1'b1;
    tick();
    ce = 1'b0;
    repeat (5) tick();
    check("mid_busy", int'(busy), 1, 0);
    arst = 1'b1;
    tick();
    check("mid_rst_busy", int'(busy), 0, 0);
    check("mid_rst_valid", int'(pv), 0, 0);
    check("mid_rst_phase", int'(phase), 0, 0);
    arst = 1'b0;
    vc = 0;
    repeat (20) begin
      tick();
      if (pv) vc++;
    end
    check("mid_rst_novalid", vc, 0, 0);
    run_vec("after_rst", 0, 63, 16'h4000, T);

    for (int p = 0; p < FULL; p += 16'h0400) begin
      run_vec("loopback", nco_cos(p), nco_sin(p), p, T);
    end

    for (int k = 0; k < 40; k++) begin
      c = int'($urandom_range(0, 127)) - 64;
      s = int'($urandom_range(0, 127)) - 64;
      run_vec("random", c, s, ideal_phase(c, s), T);
    end

`ifdef IQ_PHASE_INC_EN
    arst = 1'b1;
    tick();
    arst = 1'b0;
    tick();
    check("inc_rst", int'(pinc), 0, 0);
    run_vec("inc_v1", nco_cos(16'hF000), nco_sin(16'hF000), 16'hF000, T);
    check("inc_first", int'(pinc), 16'hF000, 2 * T);
    run_vec("inc_v2", nco_cos(16'h1000), nco_sin(16'h1000), 16'h1000, T);
    check("inc_wrap", int'(pinc), 16'h2000, 2 * T);
    run_vec("inc_v3", nco_cos(16'h1000), nco_sin(16'h1000), 16'h1000, T);
    check("inc_same", int'(pinc), 16'h0000, 2 * T);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
